spi_flash_read_seq: RTL
=======================

Name: spi_flash_read_seq

Overview:
- Sequencer that owns the byte-level SPI master engine's register interface and performs complete SPI flash/PSRAM read transactions for a single word requester, e.g. the instruction-fetch or boot-copy path.
- Per request it does five things: asserts chip select, sends the opcode, sends a 24-bit address and dummy bytes, clocks in 1–4 data bytes, then deasserts chip select.
- Each byte is carried out as engine register operations: data write, status poll, data read.

Parameters:
- OPCODE, 8'h03, read command byte sent first.
- DUMMY_BYTES, 0, number of 8'h00 bytes sent after the address (range 0–7).
- DIV, 16'd2, value driven on spi_div.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  read request.
- req_addr  in  24  byte address.
- req_len  in  2  byte count minus 1 (0 means 1 byte, 3 means 4 bytes).
- req_ready  out  1  one-cycle pulse: request done, resp_data valid.
- resp_data  out  32  received bytes, little-endian, unused upper bytes 0.
- busy  out  1  transaction in progress.
- spi_valid  out  1  engine request.
- spi_ctrl  out  1  0 selects the control/status register, 1 selects the data register.
- spi_wdata  out  32  engine write data.
- spi_wstrb  out  4  engine byte strobes; 0 means read.
- spi_div  out  16  constant DIV.
- spi_ready  in  1  engine acknowledge (may stay high for more than one cycle).
- spi_rdata  in  32  engine read data; in status reads bit31 = transfer in progress, bit0 = CS asserted.

Behaviour:
- Reset values: req_ready=0, resp_data=0, busy=0, spi_valid=0, spi_ctrl=0, spi_wdata=0, spi_wstrb=0; FSM in IDLE; all counters 0.
- Engine handshake:
  - spi_* outputs are registered.
  - spi_valid is held with stable ctrl/wdata/wstrb until the first cycle where spi_valid && spi_ready. That cycle is the acceptance; spi_rdata is sampled in it.
  - spi_valid drops on the next cycle.
  - No new spi_valid is raised until spi_ready has been observed low for at least one cycle. This is the gap rule and covers a sticky ready.
- Operation primitives:
  - CSON: ctrl=0, wdata=1, wstrb=4'b0001.
  - CSOFF: ctrl=0, wdata=0, wstrb=4'b0001.
  - WRB(b): ctrl=1, wdata={24'b0,b}, wstrb=4'b0001.
  - STAT: ctrl=0, wstrb=0.
  - RDB: ctrl=1, wstrb=0.
- FSM states: IDLE, CSON, WR, POLL, RD, CSOFF, DONE.
  - IDLE: busy=0. On req_valid, latch addr and len, clear the byte index and resp_data, busy=1, go to CSON.
  - CSON: after acceptance, go to WR.
  - WR: sends byte[idx] of the stream OPCODE, addr[23:16], addr[15:8], addr[7:0], DUMMY_BYTES×00, (len+1)×00. After acceptance, go to POLL.
  - POLL: issue STAT. If the sampled spi_rdata[31]=1, repeat POLL. Otherwise, if idx is in the data phase go to RD, else advance idx and go to WR.
  - RD: sampled spi_rdata[7:0] is written to resp_data byte lane (idx − 4 − DUMMY_BYTES). Then, if this was the last data byte go to CSOFF, else advance idx and go to WR.
  - CSOFF: after acceptance, go to DONE.
  - DONE: req_ready=1 for exactly one cycle, busy=0 next cycle, go to IDLE.
- Stream length is 4 + DUMMY_BYTES + len + 1 bytes. idx is a 4-bit counter and does not wrap within a legal request.
- req_valid and req_addr/req_len changes while busy are ignored; the latched copy is used.
- A new request seen in IDLE in the cycle after DONE is accepted; the back-to-back minimum is one IDLE cycle.
- resp_data holds its value until the next request is accepted.
- If resetn is asserted mid-transaction, everything returns immediately to reset values; spi_valid drops asynchronously. The engine's own reset restores CS.
- The POLL loop has no timeout; liveness depends on the engine.

Test Plan:
- Single byte: OPCODE=03, DUMMY=0, addr=0x123456, len=0, slave returns A5.
  - Engine sees CSON, WR 03/12/34/56/00 each followed by STAT, one RDB, CSOFF.
  - resp_data=0x000000A5, req_ready pulses once.
- Full word: len=3, slave returns 11,22,33,44 → resp_data=0x44332211; exactly 8 WR and 4 RDB operations.
- DUMMY_BYTES=1, OPCODE=0B, addr=0x000010, len=1 → byte stream 0B 00 00 10 00 00 00; resp_data captures only the last 2 bytes.
- Sticky ready: engine holds spi_ready high 3 cycles after each acceptance → no op issued until ready low; operation count is unchanged.
- Busy polling: status returns bit31=1 for 5 polls → POLL repeats 5 times, data is still correct.
- Reset at the 2nd address byte → spi_valid=0, busy=0, req_ready=0 immediately; the next request completes normally.

Source files
------------

// File: rtl/spi_flash_read_seq.sv
// Runs a full SPI flash read (CS on, opcode, address, dummy, 1-4 data bytes, CS off) through a byte engine.
// One engine op in flight; each op is held until acceptance and a new one waits for spi_ready to go low.
module spi_flash_read_seq #(
   parameter logic [7:0]  OPCODE      = 8'h03,
   parameter int unsigned DUMMY_BYTES = 0,
   parameter logic [15:0] DIV         = 16'd2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [23:0] req_addr,
   input  logic [1:0]  req_len,
   output logic        req_ready,
   output logic [31:0] resp_data,
   output logic        busy,
   output logic        spi_valid,
   output logic        spi_ctrl,
   output logic [31:0] spi_wdata,
   output logic [3:0]  spi_wstrb,
   output logic [15:0] spi_div,
   input  logic        spi_ready,
   input  logic [31:0] spi_rdata
);
   typedef enum logic [2:0] {S_IDLE, S_CSON, S_WR, S_POLL, S_RD, S_CSOFF, S_DONE} state_t;

   localparam logic [3:0] DATA_START = 4'(4 + DUMMY_BYTES);

   state_t      state_q, state_d;
   logic [23:0] addr_q, addr_d;
   logic [1:0]  len_q, len_d;
   logic [3:0]  idx_q, idx_d;
   logic [31:0] resp_q, resp_d;
   logic        rdy_low_q, rdy_low_d;
   logic        spi_valid_q, spi_valid_d;
   logic        spi_ctrl_q, spi_ctrl_d;
   logic [31:0] spi_wdata_q, spi_wdata_d;
   logic [3:0]  spi_wstrb_q, spi_wstrb_d;

   logic        accept;
   logic        gap_ok;
   logic        data_phase;
   logic        last_byte;
   logic [3:0]  data_idx;
   logic [7:0]  wr_byte;
   logic        unused_ok;

   assign accept     = spi_valid_q & spi_ready;
   // The ready-low sighting may come from this very cycle, so a fast engine costs only one idle cycle.
   assign gap_ok     = rdy_low_q | ~spi_ready;
   assign data_phase = (idx_q >= DATA_START);
   assign last_byte  = (idx_q == DATA_START + {2'b00, len_q});
   assign data_idx   = idx_q - DATA_START;
   assign unused_ok  = ^{spi_rdata[30:8], data_idx[3:2]};

   always_comb begin
      case (idx_q)
         4'd0:    wr_byte = OPCODE;
         4'd1:    wr_byte = addr_q[23:16];
         4'd2:    wr_byte = addr_q[15:8];
         4'd3:    wr_byte = addr_q[7:0];
         default: wr_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         resp_q      <= '0;
         rdy_low_q   <= 1'b0;
         spi_valid_q <= 1'b0;
         spi_ctrl_q  <= 1'b0;
         spi_wdata_q <= '0;
         spi_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         resp_q      <= resp_d;
         rdy_low_q   <= rdy_low_d;
         spi_valid_q <= spi_valid_d;
         spi_ctrl_q  <= spi_ctrl_d;
         spi_wdata_q <= spi_wdata_d;
         spi_wstrb_q <= spi_wstrb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_valid) state_d = S_CSON;
         S_CSON:  if (accept) state_d = S_WR;
         S_WR:    if (accept) state_d = S_POLL;
         S_POLL:  if (accept && !spi_rdata[31]) state_d = data_phase ? S_RD : S_WR;
         S_RD:    if (accept) state_d = last_byte ? S_CSOFF : S_WR;
         S_CSOFF: if (accept) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      addr_d      = addr_q;
      len_d       = len_q;
      idx_d       = idx_q;
      resp_d      = resp_q;
      rdy_low_d   = rdy_low_q | ~spi_ready;
      spi_valid_d = spi_valid_q;
      spi_ctrl_d  = spi_ctrl_q;
      spi_wdata_d = spi_wdata_q;
      spi_wstrb_d = spi_wstrb_q;
      if (accept) begin
         spi_valid_d = 1'b0;
         rdy_low_d   = 1'b0;
      end
      case (state_q)
         S_IDLE: if (req_valid) begin
            addr_d = req_addr;
            len_d  = req_len;
            idx_d  = '0;
            resp_d = '0;
         end
         S_POLL: if (accept && !spi_rdata[31] && !data_phase) idx_d = idx_q + 4'd1;
         S_RD: if (accept) begin
            resp_d[{data_idx[1:0], 3'b000} +: 8] = spi_rdata[7:0];
            if (!last_byte) idx_d = idx_q + 4'd1;
         end
         default: ;
      endcase
      // A state with no op outstanding issues its op once the gap rule allows.
      if (!spi_valid_q && gap_ok) begin
         case (state_q)
            S_CSON:  begin spi_valid_d = 1'b1; spi_ctrl_d = 1'b0; spi_wdata_d = 32'd1;             spi_wstrb_d = 4'b0001; end
            S_WR:    begin spi_valid_d = 1'b1; spi_ctrl_d = 1'b1; spi_wdata_d = {24'b0, wr_byte}; spi_wstrb_d = 4'b0001; end
            S_POLL:  begin spi_valid_d = 1'b1; spi_ctrl_d = 1'b0; spi_wdata_d = '0;                spi_wstrb_d = 4'b0000; end
            S_RD:    begin spi_valid_d = 1'b1; spi_ctrl_d = 1'b1; spi_wdata_d = '0;                spi_wstrb_d = 4'b0000; end
            S_CSOFF: begin spi_valid_d = 1'b1; spi_ctrl_d = 1'b0; spi_wdata_d = '0;                spi_wstrb_d = 4'b0001; end
            default: ;
         endcase
      end
   end

   assign req_ready = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign resp_data = resp_q;
   assign spi_valid = spi_valid_q;
   assign spi_ctrl  = spi_ctrl_q;
   assign spi_wdata = spi_wdata_q;
   assign spi_wstrb = spi_wstrb_q;
   assign spi_div   = DIV;

endmodule
